// File: rtl/reg_file_wb_if.sv
// Bus between the writeback/decode stages and the register file.
// Handshake: there is no valid/ready pair; every input is sampled on each
// rising clk edge (w_en qualifies the register write, Instruction_W is always
// examined for retirement) and the read outputs are combinational.
interface reg_file_wb_if;
    logic        w_en;
    logic [4:0]  RD;
    logic [31:0] result;
    logic [31:0] Instruction_W;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg_addr;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] dbg_data;
    logic [63:0] instret;
    logic [31:0] last_instr;
    logic        retire_pulse;

    // Pipeline side: drives the writeback and read indices, observes data.
    modport master (
        output w_en, RD, result, Instruction_W, rs1, rs2, dbg_addr,
        input  rdata1, rdata2, dbg_data, instret, last_instr, retire_pulse
    );

    // Register file side.
    modport slave (
        input  w_en, RD, result, Instruction_W, rs1, rs2, dbg_addr,
        output rdata1, rdata2, dbg_data, instret, last_instr, retire_pulse
    );
endinterface

// File: rtl/reg_file_wb.sv
// 32 x 32-bit register file with same-cycle write-through bypass on both read
// ports, an unbypassed debug port, and a retirement counter that ignores
// pipeline bubbles (NOP_INSTR and all-zero instructions).
module reg_file_wb #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_wb_if.slave  bus
);

    logic [31:0] regs_q [32];
    logic [63:0] instret_q,      instret_d;
    logic [31:0] last_instr_q,   last_instr_d;
    logic        retire_pulse_q, retire_pulse_d;
    logic        wr_en;
    logic        retire;

    // A write to x0 is dropped entirely, so it never reaches storage or bypass.
    always_comb begin
        wr_en  = 1'b0;
        retire = 1'b0;
        if (bus.w_en && (bus.RD != 5'd0)) begin
            wr_en = 1'b1;
        end
        if ((bus.Instruction_W != NOP_INSTR) && (bus.Instruction_W != 32'h0)) begin
            retire = 1'b1;
        end
    end

    // Retirement bookkeeping next-state; counter wraps naturally at 2^64.
    always_comb begin
        instret_d      = instret_q;
        last_instr_d   = last_instr_q;
        retire_pulse_d = 1'b0;
        if (retire) begin
            instret_d      = instret_q + 64'd1;
            last_instr_d   = bus.Instruction_W;
            retire_pulse_d = 1'b1;
        end
    end

    // Register storage; x0 is only ever cleared, never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            regs_q[bus.RD] <= bus.result;
        end
    end

    // Retirement state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q      <= 64'h0;
            last_instr_q   <= 32'h0;
            retire_pulse_q <= 1'b0;
        end else begin
            instret_q      <= instret_d;
            last_instr_q   <= last_instr_d;
            retire_pulse_q <= retire_pulse_d;
        end
    end

    // Read port 1: x0 forced to zero, then bypass, then storage.
    always_comb begin
        bus.rdata1 = 32'h0;
        if (bus.rs1 != 5'd0) begin
            if (wr_en && (bus.RD == bus.rs1)) begin
                bus.rdata1 = bus.result;
            end else begin
                bus.rdata1 = regs_q[bus.rs1];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        bus.rdata2 = 32'h0;
        if (bus.rs2 != 5'd0) begin
            if (wr_en && (bus.RD == bus.rs2)) begin
                bus.rdata2 = bus.result;
            end else begin
                bus.rdata2 = regs_q[bus.rs2];
            end
        end
    end

    // Debug port shows the stored (pre-edge) value only.
    always_comb begin
        bus.dbg_data = 32'h0;
        if (bus.dbg_addr != 5'd0) begin
            bus.dbg_data = regs_q[bus.dbg_addr];
        end
    end

    // Registered retirement outputs.
    always_comb begin
        bus.instret      = instret_q;
        bus.last_instr   = last_instr_q;
        bus.retire_pulse = retire_pulse_q;
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: table of read/write/bypass vectors, a scoreboard
// queue for the registered retirement outputs, and hand-written sequences
// for bubble filtering, counter wrap and asynchronous reset.
module tb_reg_file_wb;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    reg_file_wb_if bus ();

    reg_file_wb #(.NOP_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: {instret, last_instr, retire_pulse} expected after each edge.
    logic [96:0] exp_q [$];
    logic [63:0] m_cnt;
    logic [31:0] m_last;

    typedef struct {
        logic        w;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] instr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 64'h0;
        m_last = 32'h0;
        exp_q.delete();
    endtask

    // Drive one cycle, check combinational reads before the edge, then the
    // registered retirement outputs after it.
    task automatic step(input logic w, input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] instr, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] ad,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] ed, input string nm);
        logic        pulse;
        logic [96:0] e;
        @(negedge clk);
        bus.w_en          = w;
        bus.RD            = rd;
        bus.result        = res;
        bus.Instruction_W = instr;
        bus.rs1           = a1;
        bus.rs2           = a2;
        bus.dbg_addr      = ad;
        pulse = 1'b0;
        if ((instr != 32'h0000_0013) && (instr != 32'h0)) begin
            m_cnt  = m_cnt + 64'd1;
            m_last = instr;
            pulse  = 1'b1;
        end
        exp_q.push_back({m_cnt, m_last, pulse});
        #2;
        chk({nm, " rdata1"}, {32'h0, bus.rdata1}, {32'h0, e1});
        chk({nm, " rdata2"}, {32'h0, bus.rdata2}, {32'h0, e2});
        chk({nm, " dbg_data"}, {32'h0, bus.dbg_data}, {32'h0, ed});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({nm, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " instret"}, bus.instret, e[96:33]);
            chk({nm, " last_instr"}, {32'h0, bus.last_instr}, {32'h0, e[32:1]});
            chk({nm, " retire_pulse"}, {63'h0, bus.retire_pulse}, {63'h0, e[0]});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.w_en = 1'b0;
        bus.Instruction_W = 32'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        model_reset();
        rst = 1'b1;
        bus.w_en = 1'b0; bus.RD = 5'd0; bus.result = 32'h0; bus.Instruction_W = 32'h0;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.dbg_addr = 5'd0;

        // Reset state while clocks run.
        #22;
        chk("reset instret", bus.instret, 64'h0);
        chk("reset last_instr", {32'h0, bus.last_instr}, 64'h0);
        chk("reset retire_pulse", {63'h0, bus.retire_pulse}, 64'h0);
        bus.dbg_addr = 5'd31;
        #1;
        chk("reset dbg x31", {32'h0, bus.dbg_data}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        //          w     rd     result         instr          a1     a2     ad     e1             e2             ed
        vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0040_0093, 5'd5,  5'd0,  5'd5,  32'hDEAD_BEEF, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 5'd5,  32'h0,         32'h0000_0013, 5'd5,  5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 5'd7,  32'h0000_1234, 32'h0,         5'd7,  5'd7,  5'd7,  32'h0000_1234, 32'h0000_1234, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         32'h0000_2023, 5'd7,  5'd5,  5'd7,  32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_1234};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0,         5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         32'h0,         5'd0,  5'd7,  5'd0,  32'h0,         32'h0000_1234, 32'h0};
        vecs[6]  = '{1'b1, 5'd7,  32'hAAAA_5555, 32'hFFFF_FFFF, 5'd7,  5'd5,  5'd7,  32'hAAAA_5555, 32'hDEAD_BEEF, 32'h0000_1234};
        vecs[7]  = '{1'b1, 5'd31, 32'hCAFE_F00D, 32'h0,         5'd31, 5'd7,  5'd31, 32'hCAFE_F00D, 32'hAAAA_5555, 32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         32'h0,         5'd31, 5'd1,  5'd31, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 5'd9,  32'h1111_1111, 32'h0,         5'd9,  5'd9,  5'd9,  32'h0,         32'h0,         32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         32'h0,         5'd9,  5'd5,  5'd5,  32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].w, vecs[i].rd, vecs[i].res, vecs[i].instr, vecs[i].a1,
                 vecs[i].a2, vecs[i].ad, vecs[i].e1, vecs[i].e2, vecs[i].ed,
                 $sformatf("vec%0d", i));
        end

        // Bubble filtering: two bubbles then two real instructions.
        do_reset();
        step(1'b0, 5'd0, 32'h0, 32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "seq nop");
        step(1'b0, 5'd0, 32'h0, 32'h0000_0000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "seq zero");
        step(1'b1, 5'd1, 32'h4,  32'h0040_0093, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "seq addi");
        step(1'b0, 5'd0, 32'h0, 32'h0000_2023, 5'd1, 5'd0, 5'd1, 32'h4, 32'h0, 32'h4, "seq sw");
        chk("seq instret end", bus.instret, 64'd2);
        chk("seq last_instr end", {32'h0, bus.last_instr}, 64'h0000_2023);
        step(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "seq idle");

        // Counter wrap from all-ones.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1'b0, 5'd0, 32'h0, 32'h0000_0033, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "wrap");
        chk("wrap instret zero", bus.instret, 64'h0);

        // Asynchronous reset mid-cycle with a write and retirement in flight.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0093, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "pre rst");
        @(negedge clk);
        bus.w_en = 1'b1; bus.RD = 5'd5; bus.result = 32'h1234_5678;
        bus.Instruction_W = 32'h0000_00B3;
        bus.rs1 = 5'd5; bus.rs2 = 5'd6; bus.dbg_addr = 5'd5;
        #2;
        rst = 1'b1;
        #1;
        chk("async instret", bus.instret, 64'h0);
        chk("async last_instr", {32'h0, bus.last_instr}, 64'h0);
        chk("async retire_pulse", {63'h0, bus.retire_pulse}, 64'h0);
        chk("async dbg x5", {32'h0, bus.dbg_data}, 64'h0);
        chk("async rdata2", {32'h0, bus.rdata2}, 64'h0);
        chk("async bypass rdata1", {32'h0, bus.rdata1}, 64'h1234_5678);
        @(posedge clk);
        #1;
        chk("in-rst dbg x5", {32'h0, bus.dbg_data}, 64'h0);
        chk("in-rst instret", bus.instret, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.w_en = 1'b0;
        bus.Instruction_W = 32'h0;
        model_reset();
        step(1'b1, 5'd6, 32'h0BAD_CAFE, 32'h0000_0113, 5'd5, 5'd6, 5'd5, 32'h0, 32'h0BAD_CAFE, 32'h0, "post rst");
        step(1'b0, 5'd0, 32'h0, 32'h0, 5'd6, 5'd5, 5'd6, 32'h0BAD_CAFE, 32'h0, 32'h0BAD_CAFE, "post rst rd");

        chk("scoreboard drained", {32'h0, 32'(exp_q.size())}, 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, is the encoding the pipeline inserts as a bubble.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 w_en  input  1  write-back enable from the writeback stage.
REQ-005 RD  input  5  destination register index from the writeback stage.
REQ-006 result  input  32  write-back data from the writeback stage.
REQ-007 Instruction_W  input  32  instruction retiring in the writeback stage this cycle.
REQ-008 rs1  input  5  read port 1 index from decode.
REQ-009 rs2  input  5  read port 2 index from decode.
REQ-010 dbg_addr  input  5  debug read port index.
REQ-011 rdata1  output  32  read port 1 data, combinational.
REQ-012 rdata2  output  32  read port 2 data, combinational.
REQ-013 dbg_data  output  32  debug read data, combinational, no bypass.
REQ-014 instret  output  64  count of retired non-bubble instructions.
REQ-015 last_instr  output  32  most recently retired non-bubble instruction.
REQ-016 retire_pulse  output  1  registered, high for one cycle after each counted retirement.

Function
REQ-017 Storage SHALL be 32 x 32-bit registers; x1..x31 writable; x0 SHALL always read 0.
REQ-018 On a rising clk edge with w_en=1 and RD!=0, register[RD] SHALL take result.
REQ-019 Writes with w_en=1 and RD=0 SHALL be discarded and SHALL NOT affect any bypass.
REQ-020 rdata1 SHALL be: 0 if rs1=0; else result if w_en=1 and RD=rs1 (same-cycle write-through bypass); else register[rs1].
REQ-021 rdata2 SHALL follow REQ-020 using rs2; both ports SHALL bypass independently, including when rs1=rs2=RD.
REQ-022 dbg_data SHALL return register[dbg_addr] (0 for index 0) with no bypass, i.e. the pre-edge value.
REQ-023 A cycle is a retirement when Instruction_W != NOP_INSTR and Instruction_W != 32'h0; w_en is irrelevant, so stores and branches count.
REQ-024 On each retirement edge, instret SHALL increment by 1 with modulo-2^64 wrap (all-ones -> 0, no saturation).
REQ-025 On each retirement edge, last_instr SHALL take Instruction_W; otherwise it holds.
REQ-026 retire_pulse SHALL be 1 in the cycle after a retirement edge and 0 otherwise; back-to-back retirements keep it high.
REQ-027 Read outputs have zero latency; register writes, instret, last_instr and retire_pulse become visible one cycle after the edge.
REQ-028 The register write and the retirement update in the same cycle SHALL both take effect with no priority between them.

Reset
REQ-029 While rst=1, asynchronously, all 32 registers, instret, last_instr and retire_pulse SHALL be 0, independent of clk.
REQ-030 While rst=1, writes and retirements SHALL be ignored.
REQ-031 rdata1 and rdata2 SHALL still show the bypass value per REQ-020 while rst=1; otherwise they read 0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight write; the first edge after deassertion SHALL operate normally.

Verification
REQ-033 Write x5=32'hDEAD_BEEF, next cycle rs1=5 -> rdata1=32'hDEAD_BEEF; dbg_addr=5 -> dbg_data=32'hDEAD_BEEF.
REQ-034 w_en=1, RD=7, result=32'h1234, rs1=rs2=7 in the same cycle -> rdata1=rdata2=32'h1234 before the edge; dbg_data=old x7.
REQ-035 w_en=1, RD=0, result=32'hFFFF_FFFF, rs1=0 -> rdata1=0 before and after the edge.
REQ-036 Drive Instruction_W with 32'h0000_0013, 32'h0, 32'h0040_0093, 32'h0000_2023 on consecutive cycles -> instret ends at 2, last_instr=32'h0000_2023, retire_pulse high for two consecutive cycles.
REQ-037 Force instret to 64'hFFFF_FFFF_FFFF_FFFF and retire once -> instret=0.
REQ-038 Assert rst mid-sequence between clock edges -> all outputs 0 immediately; x5 reads 0 after deassertion.
